// File: rtl/control_pkg.sv
// Shared types and default sizing for the ack stretcher.
package control_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ack_state_t;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_HOLD_TICKS  = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ack_stretch_ch.sv
// One ack channel: synchroniser, rise detect, IDLE/HOLD FSM with tick counter
// and sticky overrun flag.
module ack_stretch_ch
  import control_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ack_in,
  input  logic clr_overrun,
  output logic ack_out,
  output logic overrun
);

  localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

  logic             synced;
  logic             prev;
  logic             rise;
  ack_state_t       state;
  logic [CNT_W-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = ack_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= ack_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = synced & ~prev;

  // A retrigger takes priority over both the terminal tick and clr_overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      ack_out <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev <= synced;
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HOLD;
            cnt     <= CNT_W'(HOLD_TICKS);
            ack_out <= 1'b1;
          end
        end
        HOLD: begin
          if (rise) begin
            cnt     <= CNT_W'(HOLD_TICKS);
            overrun <= 1'b1;
          end else if (tick) begin
            if (cnt == CNT_W'(1)) begin
              state   <= IDLE;
              cnt     <= '0;
              ack_out <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/control_ack_stretch.sv
// Multi-channel ack pulse stretcher: each ack_in pulse is held on ack_out for
// HOLD_TICKS sampling ticks so a slower sampling domain cannot miss it.
module control_ack_stretch
  import control_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] ack_in,
  input  logic              clr_overrun,
  output logic [NUM_CH-1:0] ack_out,
  output logic [NUM_CH-1:0] overrun,
  output logic              busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ack_stretch_ch #(
      .HOLD_TICKS (HOLD_TICKS),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .ack_in     (ack_in[i]),
      .clr_overrun(clr_overrun),
      .ack_out    (ack_out[i]),
      .overrun    (overrun[i])
    );
  end

  assign busy = |ack_out;

endmodule

// File: tb/tb_control_ack_stretch.sv
// Bench for control_ack_stretch: expected ack_out transitions are queued when
// stimulus is driven and matched against the DUT edge by edge.
module tb_control_ack_stretch;

  localparam int HT = 16;
  localparam int SS = 2;
  localparam int TP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       clr_overrun;
  logic [3:0] ack_in;
  logic [3:0] ack_out;
  logic [3:0] overrun;
  logic       busy;

  logic [1:0] ack_in_b;
  logic [1:0] ack_out_b;
  logic [1:0] overrun_b;
  logic       busy_b;
  logic       clr_b;

  int checks  = 0;
  int errors  = 0;
  int edge_no = 0;

  typedef struct {
    int   ch;
    logic level;
    int   edge_at;
  } ev_t;

  ev_t        sb[$];
  logic [3:0] exp_ack  = 4'b0000;
  logic [3:0] prev_obs = 4'b0000;

  control_ack_stretch #(
    .NUM_CH     (4),
    .HOLD_TICKS (HT),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ack_in     (ack_in),
    .clr_overrun(clr_overrun),
    .ack_out    (ack_out),
    .overrun    (overrun),
    .busy       (busy)
  );

  control_ack_stretch #(
    .NUM_CH     (2),
    .HOLD_TICKS (1),
    .SYNC_STAGES(0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ack_in     (ack_in_b),
    .clr_overrun(clr_b),
    .ack_out    (ack_out_b),
    .overrun    (overrun_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Tick is seen by the DUT at every edge whose number is a multiple of TP.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ((edge_no + 1) % TP == 0);
    end
  end

  always @(posedge clk) begin
    int   idx;
    logic nxt;
    bit   hit;
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].ch == ch) begin
          idx = k;
          break;
        end
      end
      hit = 1'b0;
      nxt = exp_ack[ch];
      if (idx >= 0 && sb[idx].edge_at == edge_no) begin
        nxt = sb[idx].level;
        hit = 1'b1;
        sb.delete(idx);
      end
      if (hit || ack_out[ch] !== prev_obs[ch]) begin
        checks++;
        if (ack_out[ch] !== nxt) begin
          errors++;
          $display("FAIL ack_out[%0d] at edge %0d: got %b, expected %b", ch, edge_no, ack_out[ch], nxt);
        end
      end
      exp_ack[ch]  = nxt;
      prev_obs[ch] = ack_out[ch];
    end
    checks++;
    if (busy !== |exp_ack) begin
      errors++;
      $display("FAIL busy at edge %0d: got %b, expected %b", edge_no, busy, |exp_ack);
    end
  end

  function automatic int tick_after(input int e, input int k);
    return (e / TP + k) * TP;
  endfunction

  task automatic wait_edge(input int e);
    while (edge_no < e) @(negedge clk);
  endtask

  task automatic push(input int ch, input logic lvl, input int e);
    ev_t ev;
    ev.ch      = ch;
    ev.level   = lvl;
    ev.edge_at = e;
    sb.push_back(ev);
  endtask

  task automatic drop_pending(input int ch);
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].ch == ch) sb.delete(k);
    end
  endtask

  task automatic drain(input string name, input int last);
    wait_edge(last + 2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected ack events not seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    wait_edge(4);
    checks++;
    if (ack_out !== 4'b0000) begin errors++; $display("FAIL reset_ack_out: got %b, expected 0000", ack_out); end
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun: got %b, expected 0000", overrun); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (ack_out_b !== 2'b00) begin errors++; $display("FAIL reset_ack_out_b: got %b, expected 00", ack_out_b); end
    rst = 1'b0;
    wait_edge(8);
    checks++;
    if (ack_out !== 4'b0000 || overrun !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: ack_out %b overrun %b, expected 0000/0000", ack_out, overrun);
    end
  endtask

  task automatic test_single_pulse();
    int n, r, f;
    n = edge_no + 1;
    ack_in[0] = 1'b1;
    r = n + SS;
    f = tick_after(r, HT);
    push(0, 1'b1, r);
    push(0, 1'b0, f);
    wait_edge(n);
    ack_in[0] = 1'b0;
    drain("single_pulse", f);
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL single_pulse_overrun: got %b, expected 0000", overrun); end
  endtask

  task automatic test_held_level();
    int n, r, f;
    n = edge_no + 1;
    ack_in[2] = 1'b1;
    r = n + SS;
    f = tick_after(r, HT);
    push(2, 1'b1, r);
    push(2, 1'b0, f);
    wait_edge(n + 499);
    ack_in[2] = 1'b0;
    drain("held_level", n + 520);
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL held_level_overrun: got %b, expected 0000", overrun); end
  endtask

  task automatic test_retrigger();
    int n, r, t10, r2, f2;
    n = edge_no + 1;
    ack_in[1] = 1'b1;
    r = n + SS;
    push(1, 1'b1, r);
    push(1, 1'b0, tick_after(r, HT));
    wait_edge(n);
    ack_in[1] = 1'b0;
    t10 = tick_after(r, 10);
    r2  = t10 + 3;
    f2  = tick_after(r2, HT);
    wait_edge(r2 - 3);
    ack_in[1] = 1'b1;
    drop_pending(1);
    push(1, 1'b0, f2);
    wait_edge(r2 - 2);
    ack_in[1] = 1'b0;
    wait_edge(r2 - 1);
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL retrig_pre_overrun: got %b, expected 0000", overrun); end
    wait_edge(r2);
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("FAIL retrig_overrun_set: got %b, expected 0010", overrun); end
    wait_edge(f2 + 2);
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("FAIL retrig_overrun_sticky: got %b, expected 0010", overrun); end
    clr_overrun = 1'b1;
    wait_edge(f2 + 3);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL retrig_overrun_clr: got %b, expected 0000", overrun); end
    drain("retrigger", f2 + 3);
  endtask

  task automatic test_terminal_tick();
    int n, r, f, f2;
    n = edge_no + 1;
    ack_in[3] = 1'b1;
    r = n + SS;
    f = tick_after(r, HT);
    f2 = tick_after(f, HT);
    push(3, 1'b1, r);
    push(3, 1'b0, f);
    wait_edge(n);
    ack_in[3] = 1'b0;
    wait_edge(f - 3);
    ack_in[3] = 1'b1;
    drop_pending(3);
    push(3, 1'b0, f2);
    wait_edge(f - 2);
    ack_in[3] = 1'b0;
    wait_edge(f - 1);
    clr_overrun = 1'b1;
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL terminal_pre_overrun: got %b, expected 0000", overrun); end
    wait_edge(f);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 4'b1000) begin errors++; $display("FAIL terminal_overrun_wins: got %b, expected 1000", overrun); end
    checks++;
    if (ack_out[3] !== 1'b1) begin errors++; $display("FAIL terminal_ack_held: got %b, expected 1", ack_out[3]); end
    drain("terminal_tick", f2);
    checks++;
    if (overrun !== 4'b1000) begin errors++; $display("FAIL terminal_overrun_sticky: got %b, expected 1000", overrun); end
  endtask

  task automatic test_reset_mid_hold();
    int n, r, t5;
    n = edge_no + 1;
    ack_in = 4'b1111;
    r  = n + SS;
    t5 = tick_after(r, 5);
    for (int ch = 0; ch < 4; ch++) begin
      push(ch, 1'b1, r);
      push(ch, 1'b0, t5);
    end
    wait_edge(n);
    ack_in = 4'b0000;
    wait_edge(t5 - 1);
    checks++;
    if (ack_out !== 4'b1111) begin errors++; $display("FAIL midhold_all_active: got %b, expected 1111", ack_out); end
    rst = 1'b1;
    wait_edge(t5);
    rst = 1'b0;
    checks++;
    if (ack_out !== 4'b0000) begin errors++; $display("FAIL midhold_ack_cleared: got %b, expected 0000", ack_out); end
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("FAIL midhold_overrun_cleared: got %b, expected 0000", overrun); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midhold_busy: got %b, expected 0", busy); end
    drain("reset_mid_hold", t5 + 200);
  endtask

  task automatic test_release_rise();
    int k, m, r, f;
    rst = 1'b1;
    ack_in[0] = 1'b1;
    k = edge_no + 3;
    wait_edge(k);
    rst = 1'b0;
    m = k + 1;
    r = m + SS;
    f = tick_after(r, HT);
    push(0, 1'b1, r);
    push(0, 1'b0, f);
    wait_edge(m + 20);
    ack_in[0] = 1'b0;
    drain("release_rise", f);
  endtask

  task automatic test_sync0();
    int   n;
    logic exp_b[$];
    logic e_val;
    n = ((edge_no + 2) / TP + 1) * TP;
    for (int e = n - 1; e <= n + 9; e++) exp_b.push_back(e >= n && e < n + TP);
    for (int e = n - 1; e <= n + 9; e++) begin
      wait_edge(e);
      e_val = exp_b.pop_front();
      checks++;
      if (ack_out_b[0] !== e_val || busy_b !== e_val) begin
        errors++;
        $display("FAIL sync0 at edge %0d: ack_out_b[0] %b busy_b %b, expected %b", e, ack_out_b[0], busy_b, e_val);
      end
      if (e == n - 1) ack_in_b[0] = 1'b1;
      if (e == n) ack_in_b[0] = 1'b0;
    end
    checks++;
    if (ack_out_b[1] !== 1'b0 || overrun_b !== 2'b00) begin
      errors++;
      $display("FAIL sync0_other: ack_out_b[1] %b overrun_b %b, expected 0/00", ack_out_b[1], overrun_b);
    end
  endtask

  initial begin
    rst         = 1'b1;
    ack_in      = 4'b0000;
    clr_overrun = 1'b0;
    ack_in_b    = 2'b00;
    clr_b       = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_level();
    test_retrigger();
    test_terminal_tick();
    test_reset_mid_hold();
    test_release_rise();
    test_sync0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
